// File: rtl/bist_pkg.sv
// bist_pkg: shared FSM states, LFSR taps and MISR polynomial for the BIST signature generator
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int LFSR_TAP_HI = 36;
  localparam int LFSR_TAP_LO = 25;
  localparam logic [3:0] MISR_POLY = 4'b1001;
  function automatic logic [3:0] misr_next(input logic [3:0] m, input logic [3:0] d);
    return {m[2:0], 1'b0} ^ (m[3] ? MISR_POLY : 4'b0000) ^ d;
  endfunction
endpackage

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register compacting the CUT response
module bist_misr
  import bist_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= W'(misr_next(sig, d));
endmodule

// File: rtl/bist_signature_gen.sv
// bist_signature_gen: LFSR pattern source plus MISR compaction for one BIST session
// Optional abort input is enabled by defining BIST_GEN_ABORT_EN.
module bist_signature_gen
  import bist_pkg::*;
#(
  parameter int N_W       = 36,
  parameter int S_W       = 4,
  parameter int PAT_COUNT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] seed,
  input  logic [S_W-1:0] cut_resp,
`ifdef BIST_GEN_ABORT_EN
  input  logic           abort,
`endif
  output logic [N_W-1:0] pattern,
  output logic           pattern_valid,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] sig_N,
  output logic [S_W-1:0] sig_s
);
  state_t         state, state_nx;
  logic [N_W-1:0] lfsr, tag;
  logic [15:0]    cnt;
  logic [S_W-1:0] misr;
  logic           go, last, abort_i;
`ifdef BIST_GEN_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif
  assign go            = state == IDLE && start;
  assign last          = cnt == 16'(PAT_COUNT - 1);
  assign pattern_valid = state == RUN;
  assign busy          = state != IDLE;
  assign done          = state == DONE;
  assign pattern       = pattern_valid ? lfsr : '0;
  always_comb begin
    state_nx = IDLE;
    if (go) state_nx = seed == '0 ? DONE : RUN;
    else if (state == RUN) state_nx = abort_i ? IDLE : last ? DONE : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // sig_s captures the post-update MISR value so it is valid while done is high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr  <= '0;
      tag   <= '0;
      cnt   <= '0;
      sig_N <= '0;
      sig_s <= '0;
    end else begin
      if (go) begin
        lfsr <= seed;
        tag  <= seed;
        cnt  <= '0;
      end else if (state == RUN) begin
        lfsr <= {lfsr[N_W-2:0], lfsr[LFSR_TAP_HI-1] ^ lfsr[LFSR_TAP_LO-1]};
        cnt  <= cnt + 16'd1;
      end
      if (go && seed == '0) begin
        sig_N <= '0;
        sig_s <= '0;
      end else if (state == RUN && last && !abort_i) begin
        sig_N <= tag;
        sig_s <= S_W'(misr_next(misr, cut_resp));
      end
    end
  bist_misr #(.W(S_W)) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(go),
    .en (state == RUN),
    .d  (cut_resp),
    .sig(misr)
  );
endmodule

// File: doc/bist_signature_gen.md
BIST_SIGNATURE_GEN -- requirements
Module: bist_signature_gen

Interface
REQ-001 SHALL have parameter N_W, default 36, width of the pattern tag and LFSR.
REQ-002 SHALL have parameter S_W, default 4, width of the signature and CUT response.
REQ-003 SHALL have parameter PAT_COUNT, default 64, number of patterns per session (legal range 1..65535).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a session.
REQ-007 SHALL have port seed  input  N_W  LFSR seed; also the session tag.
REQ-008 SHALL have port cut_resp  input  S_W  CUT response, combinational from pattern.
REQ-009 SHALL have port pattern  output  N_W  current test pattern to the CUT.
REQ-010 SHALL have port pattern_valid  output  1  high while pattern is being applied.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; sig_N and sig_s are updated in that cycle.
REQ-013 SHALL have port sig_N  output  N_W  seed of the last completed session, held.
REQ-014 SHALL have port sig_s  output  S_W  MISR signature of the last completed session, held.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 IDLE with start=1: SHALL load lfsr<=seed, misr<=0, cnt<=0 and go to RUN; if seed==0, SHALL go to DONE instead (zero patterns, sig_N=0, sig_s=0).
REQ-017 RUN: pattern=lfsr, pattern_valid=1; each cycle SHALL update misr<=misr_next(misr, cut_resp), advance the LFSR and increment cnt.
REQ-018 LFSR SHALL be a Fibonacci LFSR for x^36+x^25+1: lfsr<={lfsr[34:0], lfsr[35]^lfsr[24]}; the first pattern SHALL equal seed.
REQ-019 misr_next SHALL be {m[2:0],1'b0} ^ (m[3] ? 4'b1001 : 4'b0000) ^ cut_resp (polynomial x^4+x^3+1).
REQ-020 RUN SHALL move to DONE after the cycle in which cnt==PAT_COUNT-1, giving exactly PAT_COUNT pattern cycles.
REQ-021 On entry to DONE, SHALL load sig_N<=session seed and sig_s<=final misr; done=1 for that one cycle, then IDLE.
REQ-022 start in RUN or DONE SHALL be ignored; start in IDLE is accepted in the cycle after DONE.
REQ-023 cnt SHALL be 16 bits and SHALL NOT wrap within a session.
REQ-024 When pattern_valid=0, pattern SHALL be 0.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, lfsr=0, misr=0, cnt=0, pattern=0, pattern_valid=0, busy=0, done=0, sig_N=0, sig_s=0.
REQ-026 rst during RUN SHALL abandon the session, produce no done pulse and leave sig_N/sig_s at 0.

Configuration
REQ-027 With BIST_GEN_ABORT_EN defined, SHALL add port abort (input, 1); abort=1 in RUN SHALL return to IDLE next edge with no done and sig_N/sig_s unchanged; abort has priority over RUN completion.
REQ-028 Without BIST_GEN_ABORT_EN, the abort port SHALL NOT exist and a session always runs to completion.

Structure
REQ-029 A shared package bist_pkg SHALL hold the FSM state enum, LFSR tap constants (36, 25) and MISR polynomial constant 4'b1001.
REQ-030 The MISR SHALL be a sub-module bist_misr (ports clk, rst, clr, en, d, sig); the LFSR stays inline.

Verification
REQ-031 seed=0, start -> done one cycle later, sig_N=0, sig_s=0, pattern_valid never high.
REQ-032 PAT_COUNT=1, seed=36'h1, cut_resp=4'b1010 -> one pattern 36'h1, done next cycle, sig_N=36'h1, sig_s=4'b1010.
REQ-033 PAT_COUNT=3, seed=36'h1, cut_resp=4'b0001 constant -> patterns 36'h1, 36'h2, 36'h4; sig_s=4'b0111.
REQ-034 PAT_COUNT=64, start pulsed again in cycle 10 of RUN -> ignored; exactly 64 pattern cycles, single done.
REQ-035 rst asserted in cycle 5 of RUN -> all outputs 0 immediately, no done; a new start then runs normally.
REQ-036 With BIST_GEN_ABORT_EN, abort in the final RUN cycle -> no done, sig_N/sig_s keep their previous session values.
